bjp_flush_ctrl: RTL and testbench
=================================

// Module: bjp_flush_ctrl
// PURPOSE
//  Commit-side consumer of the branch/jump unit's commit results. Accepts one commit per valid/ready handshake
//  and registers any flush request (taken Bxx, JAL/JALR, MRET, DRET). Holds the redirect PC to the IFU until
//  the IFU accepts it, and stalls further commits while the redirect is outstanding.
//  Sits between the EXU/ALU commit outputs and the IFU PC-redirect and CSR trap-return inputs.
// PARAMETERS
//  none; widths come from `PC_SIZE and `XLEN in mcu_defines.v
// PORTS
//  clk               in   1         core clock; all state updates on posedge
//  rst               in   1         synchronous reset, active-high
//  cmt_i_valid       in   1         commit result valid
//  cmt_o_ready       out  1         commit result accepted this cycle when valid&ready
//  cmt_i_bjp         in   1         instruction is Bxx/JAL/JALR
//  cmt_i_mret        in   1         instruction is MRET
//  cmt_i_dret        in   1         instruction is DRET
//  cmt_i_needflush   in   1         pipeline must be redirected
//  cmt_i_flush_pc    in   PC_SIZE   redirect target
//  flush_o_valid     out  1         redirect request to IFU
//  flush_i_ready     in   1         IFU accepts redirect
//  flush_o_pc        out  PC_SIZE   redirect target, stable while flush_o_valid
//  flush_o_pend      out  1         redirect outstanding; upstream kills younger instrs
//  csr_o_mret_ena    out  1         1-cycle pulse: MRET committed
//  csr_o_dret_ena    out  1         1-cycle pulse: DRET committed
//  excp_o_misalign   out  1         1-cycle pulse: flush target misaligned, no redirect issued
//  excp_o_badaddr    out  PC_SIZE   offending target, valid with excp_o_misalign
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0, except cmt_o_ready=1.
//  FSM has 2 states: IDLE and PEND. cmt_o_ready = (state==IDLE); combinational from state only.
//  acc = cmt_i_valid & cmt_o_ready.
//  IDLE, acc, needflush=1, cmt_i_flush_pc[0]=0 -> PEND next cycle.
//   flush_o_pc<=cmt_i_flush_pc; flush_o_valid=1 from the next cycle (1-cycle latency).
//  IDLE, acc, needflush=1, flush_pc[0]=1 -> stay IDLE.
//   excp_o_misalign pulses next cycle; excp_o_badaddr<=flush_pc.
//  IDLE, acc, needflush=0 -> stay IDLE; commit retires with no side effect.
//  PEND: flush_o_valid=1; flush_o_pc and flush_o_valid are held until flush_i_ready=1.
//   Then -> IDLE next cycle. No PC change while waiting.
//  flush_o_pend = (state==PEND).
//  csr_o_mret_ena / csr_o_dret_ena: registered pulse in the cycle after acc with the matching flag.
//   Pulses exactly one cycle, independent of IFU acceptance.
//  mret and dret both set: MRET takes priority, only csr_o_mret_ena pulses.
//   Redirect still uses cmt_i_flush_pc.
//  flush_i_ready is ignored in IDLE. cmt_i_* is ignored when not accepted.
//  A ready-to-IDLE handshake and a new commit are never accepted in the same cycle.
//   This gives min 2 cycles between redirects.
//  Sync reset asserted in PEND: drops flush_o_valid next cycle, no redirect issued.
//   Pending CSR/exception pulses are cleared.
// CONFIGURATION
//  MCU_BJP_PERF_CNT_EN defined: adds outputs perf_o_bjp_cnt [XLEN] and perf_o_flush_cnt [XLEN].
//   perf_o_bjp_cnt increments on acc&cmt_i_bjp.
//   perf_o_flush_cnt increments on each IFU redirect handshake.
//   Both reset to 0, wrap modulo 2^XLEN.
//  MCU_BJP_PERF_CNT_EN undefined: no counters, no such ports; all other behaviour identical.
// STRUCTURE
//  Add to mcu_defines.v: FLUSH_ST_IDLE / FLUSH_ST_PEND state encodings (1 bit), FLUSH_ST_WIDTH.
//  Sub-module flush_pc_buf: single-entry valid/ready holding register for flush_o_pc.
//   Has load/accept/clear controls; the FSM drives it.
// TESTING
//  1. Reset held 2 cycles -> cmt_o_ready=1, flush_o_valid=0, all pulses 0.
//  2. Commit needflush=1, pc=0x0000_0100, flush_i_ready=1 -> flush_o_valid=1 one cycle later.
//     flush_o_pc=0x100; IDLE the following cycle.
//  3. Same with flush_i_ready=0 for 5 cycles -> valid/pc stable, cmt_o_ready=0 throughout.
//     Accepted on cycle 6.
//  4. Commit mret=1, needflush=1, pc=0x8000_0040 -> csr_o_mret_ena 1-cycle pulse; redirect to 0x8000_0040.
//  5. Commit needflush=1, pc=0x0000_0103 -> excp_o_misalign pulse, badaddr=0x103, flush_o_valid stays 0.
//  6. rst in PEND -> next cycle flush_o_valid=0, state IDLE.
//     With MCU_BJP_PERF_CNT_EN: 3 bjp commits, 2 taken -> bjp_cnt=3, flush_cnt=2.

Source files
------------

// File: rtl/bjp_flush_ctrl_pkg.sv
// Shared types and widths for the branch/jump flush controller.
//   PC_SIZE / XLEN     : datapath widths
//   flush_st_e         : FSM state encoding (1 bit)
//   pc_misaligned()    : redirect target alignment check
package bjp_flush_ctrl_pkg;

  localparam int PC_SIZE        = 32;
  localparam int XLEN           = 32;
  localparam int FLUSH_ST_WIDTH = 1;

  typedef enum logic [FLUSH_ST_WIDTH-1:0] {
    FLUSH_ST_IDLE = 1'b0,
    FLUSH_ST_PEND = 1'b1
  } flush_st_e;

  // Only halfword alignment is required, so only bit 0 matters.
  function automatic logic pc_misaligned(input logic [PC_SIZE-1:0] pc);
    return pc[0];
  endfunction

endpackage

// File: rtl/bjp_flush_ctrl_if.sv
// Commit-result and IFU-redirect handshake bundle.
//   cmt_*   : commit result from EXU/ALU (valid/ready)
//   flush_* : PC redirect to IFU (valid/ready)
// Modports: master = EXU/IFU side, slave = flush controller.
interface bjp_flush_ctrl_if;
  import bjp_flush_ctrl_pkg::*;

  logic               cmt_i_valid;
  logic               cmt_o_ready;
  logic               cmt_i_bjp;
  logic               cmt_i_mret;
  logic               cmt_i_dret;
  logic               cmt_i_needflush;
  logic [PC_SIZE-1:0] cmt_i_flush_pc;
  logic               flush_o_valid;
  logic               flush_i_ready;
  logic [PC_SIZE-1:0] flush_o_pc;

  modport master (
    output cmt_i_valid, cmt_i_bjp, cmt_i_mret, cmt_i_dret, cmt_i_needflush,
           cmt_i_flush_pc, flush_i_ready,
    input  cmt_o_ready, flush_o_valid, flush_o_pc
  );

  modport slave (
    input  cmt_i_valid, cmt_i_bjp, cmt_i_mret, cmt_i_dret, cmt_i_needflush,
           cmt_i_flush_pc, flush_i_ready,
    output cmt_o_ready, flush_o_valid, flush_o_pc
  );

endinterface

// File: rtl/bjp_flush_ctrl_flush_pc_buf.sv
// Single-entry holding register for the redirect PC.
//   clk      : core clock
//   i_clear  : synchronous clear (drops entry, zeroes data)
//   i_load   : capture i_data, entry becomes valid
//   i_accept : consumer takes the entry this cycle
//   i_data   : PC to hold
//   o_valid  : entry valid
//   o_data   : held PC, stable while o_valid
module bjp_flush_ctrl_flush_pc_buf
  import bjp_flush_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic               i_accept,
  input  logic [PC_SIZE-1:0] i_data,
  output logic               o_valid,
  output logic [PC_SIZE-1:0] o_data
);

  logic               r_valid;
  logic [PC_SIZE-1:0] r_data;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_accept) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/bjp_flush_ctrl.sv
// Commit-side flush controller: accepts branch/jump/xRET commit results,
// issues a PC redirect to the IFU and stalls commits until it is taken.
//   clk, rst          : core clock, synchronous active-high reset
//   bus (slave)       : commit handshake in, IFU redirect handshake out
//   flush_o_pend      : redirect outstanding
//   csr_o_mret_ena    : 1-cycle pulse, MRET committed
//   csr_o_dret_ena    : 1-cycle pulse, DRET committed (MRET wins if both)
//   excp_o_misalign   : 1-cycle pulse, odd redirect target, no redirect
//   excp_o_badaddr    : offending target, valid with excp_o_misalign
// Optional build macro MCU_BJP_PERF_CNT_EN adds perf_o_bjp_cnt and
// perf_o_flush_cnt event counters.
//
// state         | meaning
// FLUSH_ST_IDLE | ready for a commit, no redirect outstanding
// FLUSH_ST_PEND | redirect presented to IFU, commits stalled
module bjp_flush_ctrl
  import bjp_flush_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  bjp_flush_ctrl_if.slave    bus,
  output logic               flush_o_pend,
  output logic               csr_o_mret_ena,
  output logic               csr_o_dret_ena,
  output logic               excp_o_misalign,
  output logic [PC_SIZE-1:0] excp_o_badaddr
`ifdef MCU_BJP_PERF_CNT_EN
  ,
  output logic [XLEN-1:0]    perf_o_bjp_cnt,
  output logic [XLEN-1:0]    perf_o_flush_cnt
`endif
);

  flush_st_e          r_state;
  logic               r_mret_ena;
  logic               r_dret_ena;
  logic               r_misalign;
  logic [PC_SIZE-1:0] r_badaddr;

  logic w_acc;
  logic w_bad_pc;
  logic w_load;
  logic w_flush_hs;

  // Ready depends on state only, so a redirect handshake and a new commit
  // can never land in the same cycle.
  assign bus.cmt_o_ready = (r_state == FLUSH_ST_IDLE);
  assign w_acc      = bus.cmt_i_valid & bus.cmt_o_ready;
  assign w_bad_pc   = pc_misaligned(bus.cmt_i_flush_pc);
  assign w_load     = w_acc & bus.cmt_i_needflush & ~w_bad_pc;
  assign w_flush_hs = (r_state == FLUSH_ST_PEND) & bus.flush_i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FLUSH_ST_IDLE;
      r_mret_ena <= 1'b0;
      r_dret_ena <= 1'b0;
      r_misalign <= 1'b0;
      r_badaddr  <= '0;
    end else begin
      case (r_state)
        FLUSH_ST_IDLE: if (w_load)     r_state <= FLUSH_ST_PEND;
        FLUSH_ST_PEND: if (w_flush_hs) r_state <= FLUSH_ST_IDLE;
        default:                       r_state <= FLUSH_ST_IDLE;
      endcase
      r_mret_ena <= w_acc & bus.cmt_i_mret;
      r_dret_ena <= w_acc & bus.cmt_i_dret & ~bus.cmt_i_mret;
      r_misalign <= w_acc & bus.cmt_i_needflush & w_bad_pc;
      if (w_acc && bus.cmt_i_needflush && w_bad_pc)
        r_badaddr <= bus.cmt_i_flush_pc;
    end
  end

  bjp_flush_ctrl_flush_pc_buf u_pc_buf (
    .clk      (clk),
    .i_clear  (rst),
    .i_load   (w_load),
    .i_accept (bus.flush_i_ready),
    .i_data   (bus.cmt_i_flush_pc),
    .o_valid  (bus.flush_o_valid),
    .o_data   (bus.flush_o_pc)
  );

  assign flush_o_pend    = (r_state == FLUSH_ST_PEND);
  assign csr_o_mret_ena  = r_mret_ena;
  assign csr_o_dret_ena  = r_dret_ena;
  assign excp_o_misalign = r_misalign;
  assign excp_o_badaddr  = r_badaddr;

`ifdef MCU_BJP_PERF_CNT_EN
  logic [XLEN-1:0] r_bjp_cnt;
  logic [XLEN-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bjp_cnt   <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_acc && bus.cmt_i_bjp) r_bjp_cnt   <= r_bjp_cnt + 1'b1;
      if (w_flush_hs)             r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign perf_o_bjp_cnt   = r_bjp_cnt;
  assign perf_o_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_bjp_flush_ctrl.sv
module tb_bjp_flush_ctrl;
  import bjp_flush_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bjp_flush_ctrl_if bus ();

  logic               flush_o_pend;
  logic               csr_o_mret_ena;
  logic               csr_o_dret_ena;
  logic               excp_o_misalign;
  logic [PC_SIZE-1:0] excp_o_badaddr;
`ifdef MCU_BJP_PERF_CNT_EN
  logic [XLEN-1:0]    perf_o_bjp_cnt;
  logic [XLEN-1:0]    perf_o_flush_cnt;
`endif

  bjp_flush_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus.slave),
    .flush_o_pend    (flush_o_pend),
    .csr_o_mret_ena  (csr_o_mret_ena),
    .csr_o_dret_ena  (csr_o_dret_ena),
    .excp_o_misalign (excp_o_misalign),
    .excp_o_badaddr  (excp_o_badaddr)
`ifdef MCU_BJP_PERF_CNT_EN
    ,
    .perf_o_bjp_cnt  (perf_o_bjp_cnt),
    .perf_o_flush_cnt(perf_o_flush_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, bjp, m, d, nf, input logic [31:0] pc, input logic fr);
    bus.cmt_i_valid     = v;
    bus.cmt_i_bjp       = bjp;
    bus.cmt_i_mret      = m;
    bus.cmt_i_dret      = d;
    bus.cmt_i_needflush = nf;
    bus.cmt_i_flush_pc  = pc;
    bus.flush_i_ready   = fr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v, bjp, m, d, nf;
    logic [31:0] pc;
    logic        fr;
    logic        e_rdy, e_fv;
    logic [31:0] e_fpc;
    logic        e_pend, e_mret, e_dret, e_mis;
    logic [31:0] e_bad;
  } vec_t;

  function automatic vec_t mk(input logic v, bjp, m, d, nf, input logic [31:0] pc,
                              input logic fr, input logic rdy, fv, input logic [31:0] fpc,
                              input logic pend, mr, dr, mis, input logic [31:0] bad);
    vec_t r;
    r.v = v; r.bjp = bjp; r.m = m; r.d = d; r.nf = nf; r.pc = pc; r.fr = fr;
    r.e_rdy = rdy; r.e_fv = fv; r.e_fpc = fpc; r.e_pend = pend;
    r.e_mret = mr; r.e_dret = dr; r.e_mis = mis; r.e_bad = bad;
    return r;
  endfunction

  localparam int NV = 21;
  vec_t tbl [NV];

  initial begin
    // inputs applied for one clock; expectations are outputs after that edge
    //            v  b  m  d  nf pc            fr  rdy fv fpc           pd mr dr ms bad
    tbl[0]  = mk(1, 1, 0, 0, 1, 32'h100,      1,  0,  1, 32'h100,      1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 32'h0,        1,  1,  0, 32'h0,        0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, 1, 32'h200,      0,  0,  1, 32'h200,      1, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 1, 0, 1, 32'h300,      0,  0,  1, 32'h200,      1, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 1, 0, 1, 32'h300,      0,  0,  1, 32'h200,      1, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 1, 0, 1, 32'h300,      0,  0,  1, 32'h200,      1, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 1, 0, 1, 32'h300,      0,  0,  1, 32'h200,      1, 0, 0, 0, 0);
    tbl[7]  = mk(1, 0, 1, 0, 1, 32'h300,      0,  0,  1, 32'h200,      1, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 1, 0, 1, 32'h300,      1,  1,  0, 32'h0,        0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 0, 1, 0, 1, 32'h80000040, 0,  0,  1, 32'h80000040, 1, 1, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 32'h0,        1,  1,  0, 32'h0,        0, 0, 0, 0, 0);
    tbl[11] = mk(1, 1, 0, 0, 1, 32'h103,      1,  1,  0, 32'h0,        0, 0, 0, 1, 32'h103);
    tbl[12] = mk(0, 0, 0, 0, 0, 32'h0,        1,  1,  0, 32'h0,        0, 0, 0, 0, 0);
    tbl[13] = mk(1, 0, 0, 1, 1, 32'h400,      1,  0,  1, 32'h400,      1, 0, 1, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 32'h0,        1,  1,  0, 32'h0,        0, 0, 0, 0, 0);
    tbl[15] = mk(1, 0, 1, 1, 1, 32'h500,      0,  0,  1, 32'h500,      1, 1, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 32'h0,        1,  1,  0, 32'h0,        0, 0, 0, 0, 0);
    tbl[17] = mk(1, 1, 0, 0, 0, 32'h601,      1,  1,  0, 32'h0,        0, 0, 0, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 1, 32'h700,      1,  1,  0, 32'h0,        0, 0, 0, 0, 0);
    tbl[19] = mk(1, 0, 1, 0, 0, 32'h0,        1,  1,  0, 32'h0,        0, 1, 0, 0, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 32'h0,        1,  1,  0, 32'h0,        0, 0, 0, 0, 0);

    // reset held two cycles
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    tick();
    tick();
    check("rst_ready",    64'(bus.cmt_o_ready),   64'd1);
    check("rst_fvalid",   64'(bus.flush_o_valid), 64'd0);
    check("rst_fpc",      64'(bus.flush_o_pc),    64'd0);
    check("rst_pend",     64'(flush_o_pend),      64'd0);
    check("rst_mret",     64'(csr_o_mret_ena),    64'd0);
    check("rst_dret",     64'(csr_o_dret_ena),    64'd0);
    check("rst_misalign", 64'(excp_o_misalign),   64'd0);
    check("rst_badaddr",  64'(excp_o_badaddr),    64'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, tbl[i].bjp, tbl[i].m, tbl[i].d, tbl[i].nf, tbl[i].pc, tbl[i].fr);
      tick();
      check($sformatf("v%0d_ready", i),  64'(bus.cmt_o_ready),   64'(tbl[i].e_rdy));
      check($sformatf("v%0d_fvalid", i), 64'(bus.flush_o_valid), 64'(tbl[i].e_fv));
      check($sformatf("v%0d_pend", i),   64'(flush_o_pend),      64'(tbl[i].e_pend));
      check($sformatf("v%0d_mret", i),   64'(csr_o_mret_ena),    64'(tbl[i].e_mret));
      check($sformatf("v%0d_dret", i),   64'(csr_o_dret_ena),    64'(tbl[i].e_dret));
      check($sformatf("v%0d_misal", i),  64'(excp_o_misalign),   64'(tbl[i].e_mis));
      if (tbl[i].e_fv)
        check($sformatf("v%0d_fpc", i), 64'(bus.flush_o_pc), 64'(tbl[i].e_fpc));
      if (tbl[i].e_mis)
        check($sformatf("v%0d_badaddr", i), 64'(excp_o_badaddr), 64'(tbl[i].e_bad));
    end

    // reset while a redirect and an MRET pulse are pending
    drive(1, 0, 1, 0, 1, 32'h900, 0);
    tick();
    check("rstpend_pend", 64'(flush_o_pend),   64'd1);
    check("rstpend_mret", 64'(csr_o_mret_ena), 64'd1);
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    rst = 1'b1;
    tick();
    check("rstpend_fvalid", 64'(bus.flush_o_valid), 64'd0);
    check("rstpend_ready",  64'(bus.cmt_o_ready),   64'd1);
    check("rstpend_pend2",  64'(flush_o_pend),      64'd0);
    check("rstpend_mret2",  64'(csr_o_mret_ena),    64'd0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0, 1);
    tick();
    check("rstpend_after", 64'(bus.flush_o_valid), 64'd0);

`ifdef MCU_BJP_PERF_CNT_EN
    check("perf_bjp_rst",   64'(perf_o_bjp_cnt),   64'd0);
    check("perf_flush_rst", 64'(perf_o_flush_cnt), 64'd0);
    drive(1, 1, 0, 0, 1, 32'h10, 1); tick();
    drive(0, 0, 0, 0, 0, 32'h0,  1); tick();
    drive(1, 1, 0, 0, 0, 32'h0,  1); tick();
    drive(1, 1, 0, 0, 1, 32'h20, 1); tick();
    drive(0, 0, 0, 0, 0, 32'h0,  1); tick();
    check("perf_bjp",   64'(perf_o_bjp_cnt),   64'd3);
    check("perf_flush", 64'(perf_o_flush_cnt), 64'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
